dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
Sub-word load/store sequencer sitting directly upstream of the word-wide data memory, between the MEM-stage pipeline register and dm. It converts LW/LH/LHU/LB/LBU/SW/SH/SB requests into whole-word dm reads and writes. It sign/zero-extends load data and does two-cycle read-modify-write for SB/SH, because dm writes only full words. It flags misaligned and out-of-range accesses and stalls the pipeline via req_ready during RMW.

Parameters:
DM_ADDR_WIDTH, 12, byte-address width actually decoded by dm; any address bit at or above this index set = out of range.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset at posedge clk)
req_valid  input  1  access request present
req_ready  output  1  controller can accept a request this cycle
req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
req_addr  input  32  byte address
req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0]
req_pc  input  32  PC of the instruction, passed to dm for its write log
dm_read_addr  output  32  to dm read_addr
dm_read_result  input  32  from dm read_result (combinational word read)
dm_write_addr  output  32  to dm write_addr, word-aligned
dm_write_data  output  32  to dm write_data
dm_write_enable  output  1  to dm write_enable; 1 = write at next posedge
dm_curr_pc  output  32  to dm curr_pc
resp_valid  output  1  one-cycle pulse: access finished
resp_rdata  output  32  extended load data (0 for stores and errors)
resp_err  output  1  access was misaligned or out of range; dm untouched

Behaviour:
- States: IDLE, RMW_WR. req_ready = 1 only in IDLE. Accept = req_valid & req_ready.
- Byte lanes are little-endian: addr[1:0] = 0 selects bits [7:0]; half at addr[1] = 0 is [15:0], at addr[1] = 1 is [31:16].
- Error check on accept:
  - Misaligned: LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] = 1.
  - Out of range: any req_addr[31:DM_ADDR_WIDTH] bit set.
  - On error: no dm write. Next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0. Stay in IDLE.
- Loads (IDLE, accept):
  - dm_read_addr = req_addr combinationally in the accept cycle.
  - Selected byte/half is sign-extended (LH, LB) or zero-extended (LHU, LBU); LW passes the word through. Result is registered.
  - resp_valid = 1 next cycle. Latency 1.
- SW (IDLE, accept): in the same cycle drive dm_write_enable = 1, dm_write_addr = {req_addr[31:2], 2'b00}, dm_write_data = req_wdata, dm_curr_pc = req_pc. resp_valid next cycle. Latency 1.
- SB/SH (IDLE, accept):
  - dm_read_addr = word address. Register merged word = dm_read_result with the target lane replaced by req_wdata low bits. Also register the address and pc. Go to RMW_WR.
  - RMW_WR: dm_write_enable = 1 with the registered address, merged data and pc. Return to IDLE.
  - resp_valid is asserted in the cycle after RMW_WR. Latency 2; req_ready = 0 for exactly one cycle.
- dm_write_enable is 0 in every other case, including whenever rst = 0.
- dm_read_addr when no read is needed: holds req_addr (don't-care for dm).
- resp_valid is a single-cycle pulse. resp_rdata/resp_err hold until the next response.
- Reset (rst = 0 at posedge): state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0; merge/address/pc regs = 0.
  - Reset during RMW_WR: write aborted (enable forced 0), no response is produced.
  - A request presented while rst = 0 is ignored.
- Back-to-back requests accepted every cycle in IDLE. A load right after an SB/SH sees the merged word, because the dm write commits at the RMW_WR posedge before the load's read cycle.

Test Plan:
- Word 0x10 = 0x8877_6655, LB addr 0x13 -> resp_rdata 0xFFFF_FF88 after 1 cycle; LBU 0x13 -> 0x0000_0088; LH 0x12 -> 0xFFFF_8877; LHU 0x10 -> 0x0000_6655.
- Same word, SB addr 0x11 wdata 0xAB -> req_ready low 1 cycle, dm_write_enable in RMW_WR with data 0x8877_AB55 addr 0x10, resp_valid 2 cycles after accept; then LW 0x10 -> 0x8877_AB55.
- SH addr 0x12 wdata 0x1234_BEEF -> dm write 0xBEEF_AB55; SW 0x14 wdata 0xDEAD_BEEF -> single-cycle write, latency 1.
- LW 0x02, SH 0x11, SB 0x1000 with DM_ADDR_WIDTH 12 -> resp_err 1, resp_rdata 0, dm_write_enable never asserted.
- Accept SB, drive rst = 0 during RMW_WR -> no dm write, no resp_valid, req_ready 1 after reset; word unchanged.
- Stream LW, SB, LB, SW on consecutive cycles with req_valid held -> exactly 4 responses in order, SB stall respected, LB returns the merged byte.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Sub-word load/store sequencer in front of a word-wide data memory.
// Turns byte/half/word loads and stores into whole-word dm accesses, extends
// load data, and performs a two-cycle read-modify-write for SB/SH because dm
// can only write full words. Misaligned and out-of-range accesses complete
// with an error response and leave dm untouched.
module dm_access_ctrl #(
  parameter int unsigned DM_ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic [31:0] dm_read_addr,
  input  logic [31:0] dm_read_result,
  output logic [31:0] dm_write_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_write_enable,
  output logic [31:0] dm_curr_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLhu = 3'b010;
  localparam logic [2:0] OpLb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpSw  = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;
  localparam logic [2:0] OpSb  = 3'b111;

  // Address bits dm does not decode; any of them set means out of range.
  localparam logic [31:0] OorMask = (DM_ADDR_WIDTH >= 32) ? 32'd0 :
                                    ~((32'd1 << DM_ADDR_WIDTH) - 32'd1);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e      state_q;
  logic [31:0] merge_q;
  logic [31:0] addr_q;
  logic [31:0] pc_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        is_load;
  logic        is_sub_store;
  logic        misaligned;
  logic        out_of_range;
  logic        acc_err;
  logic [31:0] word_addr;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready = (state_q == StIdle);
  // Requests are ignored while reset is asserted.
  assign accept    = req_valid & req_ready & rst;
  assign word_addr = {req_addr[31:2], 2'b00};

  assign is_load      = (req_op == OpLw) | (req_op == OpLh) | (req_op == OpLhu) |
                        (req_op == OpLb) | (req_op == OpLbu);
  assign is_sub_store = (req_op == OpSh) | (req_op == OpSb);

  // Alignment and range classification of the incoming request.
  always_comb begin
    misaligned = 1'b0;
    unique case (req_op)
      OpLw, OpSw:        misaligned = (req_addr[1:0] != 2'b00);
      OpLh, OpLhu, OpSh: misaligned = req_addr[0];
      default:           misaligned = 1'b0;
    endcase
  end

  assign out_of_range = |(req_addr & OorMask);
  assign acc_err      = misaligned | out_of_range;

  // Little-endian lane selection and sign/zero extension of load data.
  always_comb begin
    sel_byte = 8'h00;
    unique case (req_addr[1:0])
      2'd0: sel_byte = dm_read_result[7:0];
      2'd1: sel_byte = dm_read_result[15:8];
      2'd2: sel_byte = dm_read_result[23:16];
      2'd3: sel_byte = dm_read_result[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = req_addr[1] ? dm_read_result[31:16] : dm_read_result[15:0];

    load_data = 32'd0;
    unique case (req_op)
      OpLw:    load_data = dm_read_result;
      OpLh:    load_data = {{16{sel_half[15]}}, sel_half};
      OpLhu:   load_data = {16'd0, sel_half};
      OpLb:    load_data = {{24{sel_byte[7]}}, sel_byte};
      OpLbu:   load_data = {24'd0, sel_byte};
      default: load_data = 32'd0;
    endcase
  end

  // Current dm word with the target byte/half lane replaced by store data.
  always_comb begin
    merged = dm_read_result;
    if (req_op == OpSb) begin
      unique case (req_addr[1:0])
        2'd0: merged[7:0]   = req_wdata[7:0];
        2'd1: merged[15:8]  = req_wdata[7:0];
        2'd2: merged[23:16] = req_wdata[7:0];
        2'd3: merged[31:24] = req_wdata[7:0];
        default: merged = dm_read_result;
      endcase
    end else if (req_op == OpSh) begin
      if (req_addr[1]) begin
        merged[31:16] = req_wdata[15:0];
      end else begin
        merged[15:0] = req_wdata[15:0];
      end
    end
  end

  // SB/SH read the containing word; everything else presents the raw address.
  assign dm_read_addr = is_sub_store ? word_addr : req_addr;

  // dm write port: RMW commit in StRmwWr, direct SW write on accept.
  always_comb begin
    dm_write_enable = 1'b0;
    dm_write_addr   = word_addr;
    dm_write_data   = req_wdata;
    dm_curr_pc      = req_pc;
    if (state_q == StRmwWr) begin
      // Reset during the commit cycle aborts the write.
      dm_write_enable = rst;
      dm_write_addr   = addr_q;
      dm_write_data   = merge_q;
      dm_curr_pc      = pc_q;
    end else if (accept && (req_op == OpSw) && !acc_err) begin
      dm_write_enable = 1'b1;
    end
  end

  // Sequencer state, RMW holding registers and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      merge_q      <= 32'd0;
      addr_q       <= 32'd0;
      pc_q         <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (acc_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else if (is_sub_store) begin
              merge_q <= merged;
              addr_q  <= word_addr;
              pc_q    <= req_pc;
              state_q <= StRmwWr;
            end else begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= is_load ? load_data : 32'd0;
            end
          end
        end
        StRmwWr: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: a behavioural word memory stands in
// for dm, a reference memory predicts results, and a scoreboard matches
// expected responses and dm writes (data, address, pc, cycle) against observed.
module tb_dm_access_ctrl;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011;
  localparam logic [2:0] LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [31:0] dm_read_addr;
  logic [31:0] dm_read_result;
  logic [31:0] dm_write_addr;
  logic [31:0] dm_write_data;
  logic        dm_write_enable;
  logic [31:0] dm_curr_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dm_access_ctrl #(.DM_ADDR_WIDTH(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_pc          (req_pc),
    .dm_read_addr    (dm_read_addr),
    .dm_read_result  (dm_read_result),
    .dm_write_addr   (dm_write_addr),
    .dm_write_data   (dm_write_data),
    .dm_write_enable (dm_write_enable),
    .dm_curr_pc      (dm_curr_pc),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err)
  );

  always #5 clk = ~clk;

  // Behavioural dm: combinational word read, write at posedge.
  logic [31:0] mem [0:1023];
  assign dm_read_result = mem[dm_read_addr[11:2]];
  always @(posedge clk) if (dm_write_enable) mem[dm_write_addr[11:2]] <= dm_write_data;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Observation logs, sampled on the falling edge.
  logic [31:0] obs_rdata [0:255];
  logic        obs_err   [0:255];
  logic [31:0] obs_cyc   [0:255];
  int          obs_wr = 0;
  logic [31:0] wl_addr [0:255];
  logic [31:0] wl_data [0:255];
  logic [31:0] wl_pc   [0:255];
  logic [31:0] wl_cyc  [0:255];
  int          wl_wr = 0;

  always @(negedge clk) begin
    if (resp_valid) begin
      obs_rdata[obs_wr[7:0]] <= resp_rdata;
      obs_err[obs_wr[7:0]]   <= resp_err;
      obs_cyc[obs_wr[7:0]]   <= cyc;
      obs_wr                 <= obs_wr + 1;
    end
    if (dm_write_enable) begin
      wl_addr[wl_wr[7:0]] <= dm_write_addr;
      wl_data[wl_wr[7:0]] <= dm_write_data;
      wl_pc[wl_wr[7:0]]   <= dm_curr_pc;
      wl_cyc[wl_wr[7:0]]  <= cyc;
      wl_wr               <= wl_wr + 1;
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] cyc;
  } wr_t;

  resp_t       exp_q[$];
  wr_t         wexp_q[$];
  logic [31:0] ref_mem [0:1023];
  int          obs_rd = 0;
  int          wl_rd = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] pc_cnt = 32'h0000_4000;

  function automatic logic [31:0] load_ref(logic [2:0] op, logic [31:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (op)
      LW:      return w;
      LH:      return 32'($signed(h));
      LHU:     return 32'(h);
      LB:      return 32'($signed(b));
      LBU:     return 32'(b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge_ref(logic [2:0] op, logic [31:0] a, logic [31:0] w,
                                            logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (op == SB) m[8*a[1:0] +: 8] = d[7:0];
    else m[16*a[1] +: 16] = d[15:0];
    return m;
  endfunction

  // Drive one request (held until accepted) and push its predicted outcome.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit track);
    int          waits;
    logic [31:0] k;
    logic [31:0] w;
    logic [31:0] nw;
    logic [31:0] wa;
    bit          err;
    @(posedge clk);
    #1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = pc_cnt;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 8) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL issue_ready: req_ready=%b required 1 within 8 cycles", req_ready);
    end
    k = cyc;
    if (track) begin
      err = (|addr[31:12]) || (((op == LW) || (op == SW)) && (addr[1:0] != 2'b00)) ||
            (((op == LH) || (op == LHU) || (op == SH)) && addr[0]);
      wa = {addr[31:2], 2'b00};
      w  = ref_mem[addr[11:2]];
      if (err) begin
        exp_q.push_back('{rdata: 32'd0, err: 1'b1, cyc: k + 1});
      end else if (op == SW) begin
        ref_mem[addr[11:2]] = wdata;
        wexp_q.push_back('{addr: wa, data: wdata, pc: pc_cnt, cyc: k});
        exp_q.push_back('{rdata: 32'd0, err: 1'b0, cyc: k + 1});
      end else if ((op == SB) || (op == SH)) begin
        nw = merge_ref(op, addr, w, wdata);
        ref_mem[addr[11:2]] = nw;
        wexp_q.push_back('{addr: wa, data: nw, pc: pc_cnt, cyc: k + 1});
        exp_q.push_back('{rdata: 32'd0, err: 1'b0, cyc: k + 2});
      end else begin
        exp_q.push_back('{rdata: load_ref(op, addr, w), err: 1'b0, cyc: k + 1});
      end
    end
    pc_cnt = pc_cnt + 32'd4;
  endtask

  // Stop driving, wait for all predicted traffic, then pop and compare.
  task automatic drain(input string name);
    resp_t e;
    wr_t   we;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 60 && (((obs_wr - obs_rd) < exp_q.size()) ||
                               ((wl_wr - wl_rd) < wexp_q.size())); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ((obs_wr - obs_rd) !== exp_q.size())
      $display("FAIL %s resp_count: got %0d required %0d", name, obs_wr - obs_rd, exp_q.size());
    else n_pass++;
    n_checks++;
    if ((wl_wr - wl_rd) !== wexp_q.size())
      $display("FAIL %s write_count: got %0d required %0d", name, wl_wr - wl_rd, wexp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_rdata[obs_rd[7:0]], obs_err[obs_rd[7:0]]} !== {e.rdata, e.err})
        $display("FAIL %s resp[%0d]: rdata=%h err=%b required rdata=%h err=%b", name, obs_rd,
                 obs_rdata[obs_rd[7:0]], obs_err[obs_rd[7:0]], e.rdata, e.err);
      else n_pass++;
      n_checks++;
      if (obs_cyc[obs_rd[7:0]] !== e.cyc)
        $display("FAIL %s resp_cycle[%0d]: got %0d required %0d", name, obs_rd,
                 obs_cyc[obs_rd[7:0]], e.cyc);
      else n_pass++;
      obs_rd++;
    end
    while (wexp_q.size() > 0 && wl_rd < wl_wr) begin
      we = wexp_q.pop_front();
      n_checks++;
      if ({wl_addr[wl_rd[7:0]], wl_data[wl_rd[7:0]], wl_pc[wl_rd[7:0]], wl_cyc[wl_rd[7:0]]}
          !== {we.addr, we.data, we.pc, we.cyc})
        $display("FAIL %s write[%0d]: addr=%h data=%h pc=%h cyc=%0d required %h %h %h %0d",
                 name, wl_rd, wl_addr[wl_rd[7:0]], wl_data[wl_rd[7:0]], wl_pc[wl_rd[7:0]],
                 wl_cyc[wl_rd[7:0]], we.addr, we.data, we.pc, we.cyc);
      else n_pass++;
      wl_rd++;
    end
    exp_q.delete();
    wexp_q.delete();
    obs_rd = obs_wr;
    wl_rd  = wl_wr;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 1'b1;
    req_op    = SW;
    req_addr  = 32'h20;
    req_wdata = 32'h1111_2222;
    req_pc    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({resp_valid, resp_rdata, resp_err} !== 34'd0)
      $display("FAIL reset_resp: valid=%b rdata=%h err=%b required 0 0 0",
               resp_valid, resp_rdata, resp_err);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready);
    else n_pass++;
    n_checks++;
    if (dm_write_enable !== 1'b0 || wl_wr != 0)
      $display("FAIL reset_no_write: we=%b writes=%0d required 0 0", dm_write_enable, wl_wr);
    else n_pass++;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_loads();
    issue(SW, 32'h10, 32'h8877_6655, 1);
    issue(LB, 32'h13, 32'h0, 1);
    issue(LBU, 32'h13, 32'h0, 1);
    issue(LH, 32'h12, 32'h0, 1);
    issue(LHU, 32'h10, 32'h0, 1);
    issue(LW, 32'h10, 32'h0, 1);
    issue(LB, 32'h10, 32'h0, 1);
    drain("loads");
  endtask

  task automatic test_rmw();
    issue(SB, 32'h11, 32'h0000_00AB, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL rmw_stall: req_ready=%b required 0", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL rmw_release: req_ready=%b required 1", req_ready);
    else n_pass++;
    issue(LW, 32'h10, 32'h0, 1);
    drain("rmw_sb");
  endtask

  task automatic test_sh_sw();
    issue(SH, 32'h12, 32'h1234_BEEF, 1);
    issue(SW, 32'h14, 32'hDEAD_BEEF, 1);
    issue(LW, 32'h10, 32'h0, 1);
    issue(LH, 32'h16, 32'h0, 1);
    drain("sh_sw");
  endtask

  task automatic test_errors();
    issue(LW, 32'h02, 32'h0, 1);
    issue(SH, 32'h11, 32'hFFFF_FFFF, 1);
    issue(SB, 32'h1000, 32'h0000_0055, 1);
    issue(SW, 32'h8000_0010, 32'h0BAD_0BAD, 1);
    issue(LW, 32'h10, 32'h0, 1);
    drain("errors");
  endtask

  task automatic test_reset_rmw();
    int r0;
    int w0;
    r0 = obs_wr;
    w0 = wl_wr;
    issue(SB, 32'h10, 32'h0000_00CC, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    n_checks++;
    if (dm_write_enable !== 1'b0) $display("FAIL rst_rmw_we: got %b required 0", dm_write_enable);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL rst_rmw_ready: got %b required 1", req_ready);
    else n_pass++;
    n_checks++;
    if (obs_wr != r0 || wl_wr != w0)
      $display("FAIL rst_rmw_quiet: resp=%0d writes=%0d required 0 0", obs_wr - r0, wl_wr - w0);
    else n_pass++;
    issue(LW, 32'h10, 32'h0, 1);
    drain("rst_rmw");
  endtask

  task automatic test_back_to_back();
    issue(LW, 32'h10, 32'h0, 1);
    issue(SB, 32'h12, 32'h0000_009A, 1);
    issue(LB, 32'h12, 32'h0, 1);
    issue(SW, 32'h18, 32'h0102_0304, 1);
    drain("back_to_back");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = LW;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_pc    = 32'd0;
    test_reset();
    test_loads();
    test_rmw();
    test_sh_sw();
    test_errors();
    test_reset_rmw();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
